// File: rtl/mux_scan_seq.sv
// mux_scan_seq: walks a mux tree's select range, waits out its pipeline latency,
// samples each channel and streams the samples as LSB-first packed bytes.
module mux_scan_seq #(
    parameter int SEL_WIDTH   = 8,
    parameter int MUX_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_WIDTH-1:0] start_idx,
    input  logic [SEL_WIDTH:0]   num_ch,
    output logic                 busy,
    output logic                 done,
    output logic [SEL_WIDTH-1:0] mux_sel,
    input  logic                 mux_out,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready
);
    localparam int CW = (MUX_LATENCY < 2) ? 1 : $clog2(MUX_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(MUX_LATENCY);
    localparam logic [SEL_WIDTH:0] NCH = (SEL_WIDTH + 1)'(1 << SEL_WIDTH);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, HOLD, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           sh_q, sh_d, data_q, data_d;
    logic                 bv_q, bv_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        bv_d    = bv_q && !byte_ready;
        case (state_q)
            IDLE: begin
                if (start && num_ch == '0) begin
                    state_d = DONE;
                end else if (start) begin
                    sel_d   = start_idx;
                    rem_d   = (num_ch > NCH) ? NCH : num_ch;
                    cnt_d   = LAT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // a zero-latency tree still spends one cycle here
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q <= CW'(1)) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                sh_d  = sh_q | (8'(mux_out) << bit_q);
                bit_d = bit_q + 3'd1;
                rem_d = rem_q - (SEL_WIDTH + 1)'(1);
                if (bit_q == 3'd7 || rem_q == (SEL_WIDTH + 1)'(1)) begin
                    state_d = HOLD;
                end else begin
                    sel_d   = sel_q + SEL_WIDTH'(1);
                    cnt_d   = LAT;
                    state_d = SETTLE;
                end
            end
            HOLD: begin
                if (!bv_q || byte_ready) begin
                    data_d = sh_q;
                    bv_d   = 1'b1;
                    sh_d   = '0;
                    bit_d  = '0;
                    if (rem_q != '0) begin
                        sel_d   = sel_q + SEL_WIDTH'(1);
                        cnt_d   = LAT;
                        state_d = SETTLE;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: state_d = (!bv_q || byte_ready) ? DONE : FLUSH;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            bv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            bv_q    <= bv_d;
        end
    end

    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign mux_sel    = sel_q;
    assign byte_data  = data_q;
    assign byte_valid = bv_q;
endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: drives a zero-latency and an 8-cycle-latency scanner against
// a modelled mux tree and checks bytes, select order and handshake behaviour.
module tb_mux_scan_seq;
    logic         clk;
    logic         rst_n;
    logic [1:0]   start_v;
    logic [7:0]   start_idx;
    logic [8:0]   num_ch;
    logic         byte_ready;
    logic [1:0]   busy, done, byte_valid, mux_out;
    logic [7:0]   mux_sel [2];
    logic [7:0]   byte_data [2];
    logic [255:0] chan;
    logic [7:0]   pipe [8] = '{default: 8'd0};

    int tests = 0;
    int fails = 0;

    int         cur = 0;
    logic [7:0] gotb [$];
    logic [7:0] sels [$];
    int         holds [$];
    int         dones = 0;
    int         bv_seen = 0;
    logic       was_busy = 1'b0;
    logic [7:0] prev_sel = 8'd0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mux_scan_seq #(.SEL_WIDTH(8), .MUX_LATENCY(g * 8)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[g]), .start_idx(start_idx),
            .num_ch(num_ch), .busy(busy[g]), .done(done[g]), .mux_sel(mux_sel[g]),
            .mux_out(mux_out[g]), .byte_data(byte_data[g]), .byte_valid(byte_valid[g]),
            .byte_ready(byte_ready)
        );
    end

    // instance 0 sees a combinational tree, instance 1 an 8-stage registered one
    always @(posedge clk) begin
        pipe[0] <= mux_sel[1];
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign mux_out[0] = chan[mux_sel[0]];
    assign mux_out[1] = chan[pipe[7]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid[cur] && byte_ready) gotb.push_back(byte_data[cur]);
        if (byte_valid[cur]) bv_seen++;
        if (done[cur]) dones++;
        if (busy[cur]) begin
            if (!was_busy || mux_sel[cur] != prev_sel) begin
                sels.push_back(mux_sel[cur]);
                holds.push_back(1);
            end else begin
                holds[holds.size()-1] = holds[holds.size()-1] + 1;
            end
        end
        was_busy = busy[cur];
        prev_sel = mux_sel[cur];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx, input int m, input int b);
        logic [7:0] r = 8'd0;
        for (int j = 0; j < 8; j++)
            if (b * 8 + j < m) r[j] = chan[(idx + b * 8 + j) % 256];
        return r;
    endfunction

    function automatic logic [7:0] gb(input int b);
        return (b < gotb.size()) ? gotb[b] : 8'hxx;
    endfunction

    task automatic rand_chan();
        for (int i = 0; i < 256; i++) chan[i] = 1'($urandom);
    endtask

    task automatic scan(input int k, input int idx, input int n, input bit stall, input bit poke);
        int m, nb, t, bad, hexp;
        logic [7:0] d0, s0;
        m = (n > 256) ? 256 : n;
        nb = (m + 7) / 8;
        hexp = (k == 1) ? 9 : 2;
        gotb.delete(); sels.delete(); holds.delete();
        dones = 0; bv_seen = 0; cur = k; was_busy = 1'b0;
        @(posedge clk); #1;
        start_idx = 8'(idx); num_ch = 9'(n); start_v[k] = 1'b1; byte_ready = !stall;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        @(negedge clk);
        if (n == 0) chk("zero_done_next", 32'(done[k]), 1);
        else chk("busy_rise", 32'(busy[k]), 1);
        if (poke) begin
            repeat (6) @(posedge clk);
            #1; start_idx = 8'(idx + 77); num_ch = 9'd5; start_v[k] = 1'b1;
            @(posedge clk); #1;
            start_v[k] = 1'b0;
        end
        if (stall) begin
            t = 0;
            while (byte_valid[k] !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
            chk("stall_valid", 32'(byte_valid[k]), 1);
            d0 = byte_data[k]; s0 = 8'd0; bad = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (byte_valid[k] !== 1'b1 || byte_data[k] !== d0) bad++;
                if (c == 30) s0 = mux_sel[k];
                if (c > 30 && mux_sel[k] !== s0) bad++;
            end
            chk("stall_stable", bad, 0);
            @(posedge clk); #1;
            byte_ready = 1'b1;
        end
        t = 0;
        while (done[k] !== 1'b1 && t < 20000) begin @(negedge clk); t++; end
        chk("done_seen", 32'(done[k]), 1);
        @(negedge clk);
        chk("done_one_cycle", {done[k], busy[k]}, 0);
        chk("done_count", dones, 1);
        chk("nbytes", gotb.size(), nb);
        for (int b = 0; b < nb; b++) chk("byte", gb(b), exp_byte(idx, m, b));
        bad = (sels.size() != m) ? 1 : 0;
        for (int i = 0; i < sels.size(); i++) begin
            if (sels[i] !== 8'(idx + i)) bad++;
            if (!stall && i < m - 1 && i % 8 != 7 && holds[i] != hexp) bad++;
        end
        chk("sel_seq", bad, 0);
        if (n == 0) chk("zero_no_valid", bv_seen, 0);
    endtask

    initial begin
        int t;
        logic [7:0] pat;
        rst_n = 1'b0; start_v = 2'b00; start_idx = 8'd0; num_ch = 9'd0; byte_ready = 1'b1;
        chan = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out0", {busy[0], done[0], byte_valid[0], mux_sel[0], byte_data[0]}, 0);
        chk("rst_out1", {busy[1], done[1], byte_valid[1], mux_sel[1], byte_data[1]}, 0);
        rst_n = 1'b1;

        pat = 8'hA5;
        for (int i = 0; i < 256; i++) chan[i] = pat[i % 8];
        scan(0, 0, 8, 1'b0, 1'b0);
        chk("basic_a5", gb(0), 8'hA5);
        scan(1, 0, 16, 1'b0, 1'b0);
        chk("lat_a5_b1", gb(1), 8'hA5);
        rand_chan();
        scan(1, int'($urandom_range(0, 255)), 16, 1'b0, 1'b0);

        rand_chan();
        chan[254] = 1'b1; chan[255] = 1'b0; chan[0] = 1'b1;
        scan(0, 254, 3, 1'b0, 1'b0);
        chk("wrap_byte", gb(0), 8'h05);

        rand_chan();
        scan(0, int'($urandom_range(0, 255)), 24, 1'b1, 1'b0);
        scan(0, int'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
        rand_chan();
        scan(0, int'($urandom_range(0, 255)), 300, 1'b0, 1'b1);
        scan(1, int'($urandom_range(0, 255)), 20, 1'b0, 1'b1);

        rand_chan();
        cur = 1; byte_ready = 1'b0;
        @(posedge clk); #1;
        start_idx = 8'($urandom); num_ch = 9'd16; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        t = 0;
        while (byte_valid[1] !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        chk("rstmid_pending", 32'(byte_valid[1]), 1);
        repeat (3) @(posedge clk);
        #1; dones = 0; rst_n = 1'b0;
        #1;
        chk("rstmid_out", {busy[1], done[1], byte_valid[1], mux_sel[1], byte_data[1]}, 0);
        repeat (2) @(negedge clk);
        chk("rstmid_nodone", dones, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; byte_ready = 1'b1;
        scan(1, int'($urandom_range(0, 255)), 16, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rand_chan();
            scan(r % 2, int'($urandom_range(0, 255)), int'($urandom_range(1, 40)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Upstream sequencer and downstream collector for the registered 256:1 mux tree.
- Drives the tree's select bus across a contiguous range of channels.
- Waits out the tree's pipeline latency, then samples the tree's 1-bit output.
- Packs samples LSB-first into bytes and delivers them over a valid/ready stream to the capture logic.

Parameters:
SEL_WIDTH, 8, select width of the mux tree (2^SEL_WIDTH channels)
MUX_LATENCY, 8, clock cycles from mux_sel change to a valid mux_out (0 = combinational tree)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  scan request; sampled only in IDLE
start_idx  in  SEL_WIDTH  first channel of the scan
num_ch  in  SEL_WIDTH+1  channels to scan
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan completion
mux_sel  out  SEL_WIDTH  select to the mux tree, registered
mux_out  in  1  output bit from the mux tree
byte_data  out  8  packed samples
byte_valid  out  1  byte_data valid
byte_ready  in  1  consumer accepts byte

Behaviour:
- Reset (async assert, sync release): state IDLE; mux_sel=0, busy=0, done=0, byte_valid=0, byte_data=0. Clears the bit counter, channel counter and shift register. A byte pending at reset is discarded.
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, named rst_n.
- States: IDLE, SETTLE, SAMPLE, HOLD, FLUSH, DONE.
- IDLE:
  - start=1 with num_ch!=0: mux_sel<=start_idx, remaining<=min(num_ch, 2^SEL_WIDTH), settle counter<=MUX_LATENCY, go SETTLE, busy<=1.
  - start=1 with num_ch=0: go DONE directly; no bytes emitted.
  - start is ignored in every state except IDLE.
- SETTLE: decrement the counter each cycle. When it reads 0, go SAMPLE. With MUX_LATENCY=0, SETTLE lasts one cycle.
- SAMPLE: shift mux_out into bit position bitcnt (first channel lands in bit 0); remaining-=1.
  - bitcnt reaches 8, or remaining reaches 0: the byte is complete. Upper unfilled bits are 0. Go HOLD.
  - Otherwise: mux_sel<=mux_sel+1 (wraps modulo 2^SEL_WIDTH, so 255+1=0), reload the settle counter, go SETTLE.
- HOLD: load the completed byte into the output register when byte_valid=0, or when byte_valid&&byte_ready in the same cycle. Then clear the shift register and bitcnt.
  - remaining>0: advance mux_sel, go SETTLE.
  - remaining=0: go FLUSH.
  - Output register occupied and not accepted: stay in HOLD. mux_sel is held and no sampling occurs.
- Output register: byte_valid stays high and byte_data stays stable until a cycle with byte_ready=1. byte_ready with byte_valid=0 has no effect.
- FLUSH: wait until the last byte is accepted (byte_valid&&byte_ready), then go DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE. A start in the DONE cycle is ignored.
- Per-channel cost: MUX_LATENCY+1 cycles, plus one HOLD cycle per byte when unstalled.
- Bytes per scan: ceil(remaining/8).
- Scan length: num_ch > 2^SEL_WIDTH clamps to 2^SEL_WIDTH.
- Reset mid-scan: immediate return to reset values; no done pulse.

Test Plan:
- Basic scan, combinational tree:
  - Setup: MUX_LATENCY=0, model mux_out=pattern[mux_sel] with pattern=0xA5 repeating; start_idx=0, num_ch=8, byte_ready=1.
  - Required: one byte 0xA5; mux_sel visits 0..7 in order; done pulses once; busy low afterwards.
- Latency honoured:
  - Setup: MUX_LATENCY=8, model delays mux_out by 8 cycles, num_ch=16.
  - Required: two bytes matching the pattern; each mux_sel value held for 9 cycles; the sample taken is never from the prior channel.
- Wrap and partial byte:
  - Setup: start_idx=254, num_ch=3, channels 254/255/0 = 1/0/1.
  - Required: mux_sel sequence 254, 255, 0; single byte 0x05; done pulses.
- Backpressure:
  - Setup: num_ch=24, byte_ready=0 for 50 cycles after the first byte_valid.
  - Required: byte_data stable throughout the stall; mux_sel frozen in HOLD; all 3 bytes correct and in order; no byte lost or duplicated.
- Edge commands:
  - num_ch=0: done one cycle after start, no byte_valid.
  - num_ch=300: exactly 256 channels, 32 bytes.
  - start while busy: ignored.
- Reset mid-scan:
  - Setup: assert rst_n=0 during SETTLE with a pending byte.
  - Required: all outputs zero immediately; no done pulse; a new scan afterwards is correct.
